execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_pkg.sv | 55 +++++
 rtl/shifter.sv | 32 +++
 rtl/execute_stage.sv | 129 ++++++++++++
 tb/tb_execute_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: opcode constants, execute-phase value and helpers shared by the pipeline stages
package execute_stage_pkg;

    localparam logic [2:0] EXEC_PHASE = 3'b011;

    // Instruction classes, instr[15:14]; 00 and 01 are both load/store
    localparam logic [1:0] CLS_LS0   = 2'b00;
    localparam logic [1:0] CLS_LS1   = 2'b01;
    localparam logic [1:0] CLS_IMM   = 2'b10;
    localparam logic [1:0] CLS_ARITH = 2'b11;

    // Arithmetic-class op3 codes, instr[7:4]
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Immediate/branch sub codes, instr[13:11]
    localparam logic [2:0] SUB_LI = 3'b000;
    localparam logic [2:0] SUB_B  = 3'b100;
    localparam logic [2:0] SUB_BC = 3'b111;

    // Conditional-branch cond codes, instr[10:8]
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    // Shift modes line up with op3[1:0] of the shift opcodes
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_ROL = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_mode_e;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/shifter.sv
// shifter: 16-bit barrel shifter for the execute stage
//   data   in  16  value to shift
//   amount in  4   shift distance 0..15
//   mode   in  2   SLL / rotate-left / SRL / SRA
//   result out 16  shifted value
//   carry  out 1   last bit shifted out, 0 when amount is 0
module shifter
    import execute_stage_pkg::*;
(
    input  logic [15:0] data,
    input  logic [3:0]  amount,
    input  shift_mode_e mode,
    output logic [15:0] result,
    output logic        carry
);
    // Each path carries one guard bit so the last bit shifted out falls into it
    logic [16:0] left, right, arith;
    logic [31:0] rot;
    assign left  = {1'b0, data} << amount;
    assign right = {data, 1'b0} >> amount;
    assign arith = $signed({data, 1'b0}) >>> amount;
    assign rot   = {data, data} << amount;
    always_comb begin
        result = mode == SH_SLL ? left[15:0] :
                 mode == SH_ROL ? rot[31:16] :
                 mode == SH_SRL ? right[16:1] : arith[16:1];
        // A rotated-out msb reappears at bit 0; a zero rotate shifts nothing out
        carry  = mode == SH_SLL ? left[16] :
                 mode == SH_ROL ? (amount != 4'd0) && rot[16] :
                 mode == SH_SRL ? right[0] : arith[0];
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU, address and branch-target execution with registered result and flags
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   phase_counter                outputs update only in phase 3'b011
//   instruction_register_wire    current instruction
//   ar, br, pc                   rs operand, rd operand, incremented pc
//   dr                           registered result / effective address / branch target
//   flag_s/z/c/v                 registered condition flags
//   branch_taken                 high when dr holds a taken branch target
//   halt                         sticky until reset
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  phase_counter,
    input  logic [15:0] instruction_register_wire,
    input  logic [15:0] ar,
    input  logic [15:0] br,
    input  logic [15:0] pc,
    output logic [15:0] dr,
    output logic        flag_s,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic        branch_taken,
    output logic        halt
);
    logic [1:0]  cls;
    logic [3:0]  op3;
    logic [3:0]  d;
    logic [2:0]  sub;
    logic [2:0]  cond;
    logic [7:0]  d8;
    logic [15:0] sum, diff, target, sh_res, res;
    logic        add_c, add_v, sub_v, sh_c, set_flags;
    logic [1:0]  cv;
    logic [15:0] dr_n;
    logic        s_n, z_n, c_n, v_n, bt_n, halt_n;

    assign cls  = instruction_register_wire[15:14];
    assign sub  = instruction_register_wire[13:11];
    assign cond = instruction_register_wire[10:8];
    assign d8   = instruction_register_wire[7:0];
    assign op3  = instruction_register_wire[7:4];
    assign d    = instruction_register_wire[3:0];

    assign {add_c, sum} = {1'b0, br} + {1'b0, ar};
    assign diff   = br - ar;
    assign add_v  = (br[15] == ar[15]) && (sum[15] != br[15]);
    assign sub_v  = (br[15] != ar[15]) && (diff[15] != br[15]);
    assign target = pc + sext8(d8);

    shifter u_shifter (
        .data   (br),
        .amount (d),
        .mode   (shift_mode_e'(op3[1:0])),
        .result (sh_res),
        .carry  (sh_c)
    );

    always_comb begin
        dr_n      = dr;
        s_n       = flag_s;
        z_n       = flag_z;
        c_n       = flag_c;
        v_n       = flag_v;
        bt_n      = 1'b0;
        halt_n    = halt;
        res       = 16'h0000;
        cv        = 2'b00;
        set_flags = 1'b0;
        if (cls == CLS_ARITH) begin
            case (op3)
                OP_ADD: begin res = sum; cv = {add_c, add_v}; set_flags = 1'b1; end
                OP_SUB, OP_CMP: begin res = diff; cv = {br < ar, sub_v}; set_flags = 1'b1; end
                OP_AND: begin res = br & ar; set_flags = 1'b1; end
                OP_OR:  begin res = br | ar; set_flags = 1'b1; end
                OP_XOR: begin res = br ^ ar; set_flags = 1'b1; end
                OP_MOV: begin res = ar; set_flags = 1'b1; end
                OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin res = sh_res; cv = {sh_c, 1'b0}; set_flags = 1'b1; end
                OP_IN, OP_OUT: dr_n = ar;
                OP_HLT: halt_n = 1'b1;
                default: ;
            endcase
            if (set_flags) begin
                dr_n       = res;
                s_n        = res[15];
                z_n        = res == 16'h0000;
                {c_n, v_n} = cv;
            end
        end else if (cls == CLS_IMM) begin
            case (sub)
                SUB_LI: dr_n = sext8(d8);
                SUB_B: begin dr_n = target; bt_n = 1'b1; end
                SUB_BC: begin
                    dr_n = target;
                    // Conditions see the flags of the previous flag-setting instruction
                    bt_n = cond == COND_BE  ? flag_z :
                           cond == COND_BLT ? flag_s ^ flag_v :
                           cond == COND_BLE ? flag_z | (flag_s ^ flag_v) :
                           cond == COND_BNE ? ~flag_z : 1'b0;
                end
                default: ;
            endcase
        end else begin
            dr_n = br + sext4(d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dr           <= 16'h0000;
            flag_s       <= 1'b0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            flag_v       <= 1'b0;
            branch_taken <= 1'b0;
            halt         <= 1'b0;
        end else if (phase_counter == EXEC_PHASE) begin
            dr           <= dr_n;
            flag_s       <= s_n;
            flag_z       <= z_n;
            flag_c       <= c_n;
            flag_v       <= v_n;
            branch_taken <= bt_n;
            halt         <= halt_n;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a behavioural model
module tb_execute_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  phase_counter = 3'b000;
    logic [15:0] instruction_register_wire = 16'h0000;
    logic [15:0] ar = 16'h0000, br = 16'h0000, pc = 16'h0000;
    logic [15:0] dr;
    logic        flag_s, flag_z, flag_c, flag_v, branch_taken, halt;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_dr;
    logic        m_s, m_z, m_c, m_v, m_bt, m_halt;

    execute_stage dut (
        .clock                     (clock),
        .reset                     (reset),
        .phase_counter             (phase_counter),
        .instruction_register_wire (instruction_register_wire),
        .ar                        (ar),
        .br                        (br),
        .pc                        (pc),
        .dr                        (dr),
        .flag_s                    (flag_s),
        .flag_z                    (flag_z),
        .flag_c                    (flag_c),
        .flag_v                    (flag_v),
        .branch_taken              (branch_taken),
        .halt                      (halt)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] arith(input logic [3:0] op, input logic [3:0] dd);
        return {2'b11, 6'b000000, op, dd};
    endfunction

    function automatic logic [15:0] immb(input logic [2:0] sb, input logic [2:0] cd, input logic [7:0] v);
        return {2'b10, sb, cd, v};
    endfunction

    task automatic model_reset();
        m_dr = 16'h0000;
        {m_s, m_z, m_c, m_v, m_bt, m_halt} = 6'b000000;
    endtask

    // Behavioural reference: integer arithmetic and bit-at-a-time shifting
    task automatic model_exec(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
        int op, sb, cd, ua, ub, sa, sbv, r, off;
        logic c, v, fl;
        logic [15:0] x;
        op  = int'(ins[7:4]);
        sb  = int'(ins[13:11]);
        cd  = int'(ins[10:8]);
        ua  = int'(a);
        ub  = int'(b);
        sa  = a[15] ? ua - 65536 : ua;
        sbv = b[15] ? ub - 65536 : ub;
        off = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
        r = 0; c = 1'b0; v = 1'b0; fl = 1'b0;
        m_bt = 1'b0;
        if (ins[15:14] == 2'b11) begin
            case (op)
                0: begin r = ub + ua; c = r > 65535; v = (sbv + sa > 32767) || (sbv + sa < -32768); fl = 1'b1; end
                1, 5: begin r = ub - ua; c = ub < ua; v = (sbv - sa > 32767) || (sbv - sa < -32768); fl = 1'b1; end
                2: begin r = ub & ua; fl = 1'b1; end
                3: begin r = ub | ua; fl = 1'b1; end
                4: begin r = ub ^ ua; fl = 1'b1; end
                6: begin r = ua; fl = 1'b1; end
                8, 9, 10, 11: begin
                    x = b;
                    repeat (int'(ins[3:0])) begin
                        case (op)
                            8:  begin c = x[15]; x = {x[14:0], 1'b0}; end
                            9:  begin c = x[15]; x = {x[14:0], x[15]}; end
                            10: begin c = x[0]; x = {1'b0, x[15:1]}; end
                            default: begin c = x[0]; x = {x[15], x[15:1]}; end
                        endcase
                    end
                    r = int'(x); fl = 1'b1;
                end
                12, 13: m_dr = a;
                15: m_halt = 1'b1;
                default: ;
            endcase
            if (fl) begin
                m_dr = 16'(r);
                m_s = m_dr[15];
                m_z = m_dr == 16'h0000;
                m_c = c;
                m_v = v;
            end
        end else if (ins[15:14] == 2'b10) begin
            if (sb == 0) m_dr = 16'(off);
            if (sb == 4) begin m_dr = 16'(int'(p) + off); m_bt = 1'b1; end
            if (sb == 7) begin
                m_dr = 16'(int'(p) + off);
                m_bt = cd == 0 ? m_z : cd == 1 ? (m_s != m_v) : cd == 2 ? (m_z || (m_s != m_v)) : cd == 3 ? !m_z : 1'b0;
            end
        end else begin
            m_dr = 16'(ub + (ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0])));
        end
    endtask

    task automatic expect16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] ph, input logic [15:0] ins,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
        @(negedge clock);
        reset = rst;
        phase_counter = ph;
        instruction_register_wire = ins;
        ar = a;
        br = b;
        pc = p;
        @(posedge clock);
        if (rst) model_reset();
        else if (ph == 3'b011) model_exec(ins, a, b, p);
        #1;
        expect16("dr", dr, m_dr);
        expect16("flags_szcv_bt_halt", {10'd0, flag_s, flag_z, flag_c, flag_v, branch_taken, halt},
                 {10'd0, m_s, m_z, m_c, m_v, m_bt, m_halt});
    endtask

    initial begin
        logic [15:0] held;
        model_reset();
        step(1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step(1'b1, 3'b011, arith(4'h0, 4'h0), 16'h1111, 16'h2222, 16'h0000);
        expect16("reset_dr", dr, 16'h0000);
        // ADD overflow
        step(1'b0, 3'b011, arith(4'h0, 4'h0), 16'h0001, 16'h7FFF, 16'h0000);
        expect16("add_ovf_dr", dr, 16'h8000);
        expect16("add_ovf_szcv", {12'd0, flag_s, flag_z, flag_c, flag_v}, 16'h0009);
        // SUB borrow, CMP equal
        step(1'b0, 3'b011, arith(4'h1, 4'h0), 16'h0005, 16'h0003, 16'h0000);
        expect16("sub_dr", dr, 16'hFFFE);
        expect16("sub_szcv", {12'd0, flag_s, flag_z, flag_c, flag_v}, 16'h000A);
        step(1'b0, 3'b011, arith(4'h5, 4'h0), 16'h1234, 16'h1234, 16'h0000);
        expect16("cmp_dr_z", {flag_z, dr[14:0]}, 16'h8000);
        // Branches with Z set
        step(1'b0, 3'b011, immb(3'b111, 3'b000, 8'hFC), 16'h0000, 16'h0000, 16'h0010);
        expect16("be_dr", dr, 16'h000C);
        expect16("be_taken", {15'd0, branch_taken}, 16'h0001);
        step(1'b0, 3'b011, immb(3'b111, 3'b011, 8'hFC), 16'h0000, 16'h0000, 16'h0010);
        expect16("bne_taken", {15'd0, branch_taken}, 16'h0000);
        // Shifts of 8001
        step(1'b0, 3'b011, arith(4'hB, 4'h1), 16'h0000, 16'h8001, 16'h0000);
        expect16("sra_dr_c", dr ^ {15'd0, flag_c}, 16'hC001);
        step(1'b0, 3'b011, arith(4'h9, 4'h4), 16'h0000, 16'h8001, 16'h0000);
        expect16("slr_dr", dr, 16'h0018);
        step(1'b0, 3'b011, arith(4'h8, 4'h0), 16'h0000, 16'h8001, 16'h0000);
        expect16("sll0_dr", dr, 16'h8001);
        expect16("sll0_c", {15'd0, flag_c}, 16'h0000);
        // Hold outside the execute phase
        held = dr;
        step(1'b0, 3'b000, arith(4'h0, 4'h0), 16'h0101, 16'h0202, 16'h0000);
        step(1'b0, 3'b001, arith(4'h0, 4'h0), 16'h0101, 16'h0202, 16'h0000);
        step(1'b0, 3'b010, arith(4'h0, 4'h0), 16'h0101, 16'h0202, 16'h0000);
        step(1'b0, 3'b100, arith(4'h0, 4'h0), 16'h0101, 16'h0202, 16'h0000);
        expect16("hold_dr", dr, held);
        // Halt is sticky
        step(1'b0, 3'b011, arith(4'hF, 4'h0), 16'h0101, 16'h0202, 16'h0000);
        expect16("hlt_dr", dr, held);
        step(1'b0, 3'b011, arith(4'h0, 4'h0), 16'h0101, 16'h0202, 16'h0000);
        expect16("halt_sticky", {15'd0, halt}, 16'h0001);
        // Load/store address, LI, IN
        step(1'b0, 3'b011, 16'h4A0E, 16'h0000, 16'h0100, 16'h0000);
        expect16("ls_addr", dr, 16'h00FE);
        step(1'b0, 3'b011, immb(3'b000, 3'b000, 8'h80), 16'h0000, 16'h0000, 16'h0000);
        expect16("li_dr", dr, 16'hFF80);
        // Reset beats a simultaneous execute update
        step(1'b1, 3'b011, arith(4'h0, 4'h0), 16'h0001, 16'h7FFF, 16'h0000);
        expect16("reset_prio", {dr[14:0], halt}, 16'h0000);
        // Randomized
        for (int i = 0; i < 500; i++) begin
            logic [2:0] ph;
            ph = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b011;
            step($urandom_range(0, 39) == 0, ph, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
